fir_mac_param: RTL and testbench

Parametrised, single-MAC, memory-to-memory FIR engine. It is the successor to the team's fixed 5-tap non-pipelined FIR.
- Generalised in tap count, data, coefficient and accumulator width, output scaling and saturation.
- Coefficients are runtime-loadable.
- Memory reads are pipelined: one tap per clock against a 1-cycle-latency synchronous RAM.
- Sits between the controller (start/done) and the shared dual-port sample RAM: port A reads, port B writes.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac_param_if.sv | 41 ++++
 rtl/fir_coef_bank.sv | 38 +++
 rtl/fir_mac_param.sv | 172 +++++++++++++++++
 tb/tb_fir_mac_param.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised FIR MAC engine: FSM encoding,
// default coefficient set and a saturation helper.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Hard upper bound on the tap count; the coefficient index is 4 bits wide.
  localparam int MAX_TAPS = 16;

  // Taps 0..4 reproduce the old fixed 5-tap filter; the rest are zero.
  localparam int DEFAULT_COEF [MAX_TAPS] = '{1, 2, 3, 2, 1, 0, 0, 0,
                                             0, 0, 0, 0, 0, 0, 0, 0};

  // Clamp a signed value into the signed range of a 'bits'-wide word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fir_mac_param_if.sv
// Controller, coefficient-load and dual-port sample RAM signals of the FIR
// engine. 'slave' is the engine's view, 'master' is the surrounding system.
interface fir_mac_param_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] input_addr;
  logic [ADDR_W-1:0] output_addr;
  logic [ADDR_W-1:0] sample_count;
  logic              busy;
  logic              done;
  logic              coef_we;
  logic [3:0]        coef_idx;
  logic [COEF_W-1:0] coef_data;
  logic [ADDR_W-1:0] mem_addr_a;
  logic              mem_re_a;
  logic [DATA_W-1:0] mem_data_out_a;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_data_in_b;
  logic              mem_we_b;

  modport slave (
    input  start, input_addr, output_addr, sample_count,
    input  coef_we, coef_idx, coef_data,
    input  mem_data_out_a,
    output busy, done,
    output mem_addr_a, mem_re_a,
    output mem_addr_b, mem_data_in_b, mem_we_b
  );

  modport master (
    output start, input_addr, output_addr, sample_count,
    output coef_we, coef_idx, coef_data,
    output mem_data_out_a,
    input  busy, done,
    input  mem_addr_a, mem_re_a,
    input  mem_addr_b, mem_data_in_b, mem_we_b
  );
endinterface

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient register file with a combinational read port.
// Writes are blocked while the engine is running so a run never sees a mix
// of old and new taps.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W   = 8,
  parameter int NUM_TAPS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lock,
  input  logic                     we,
  input  logic [3:0]               wr_idx,
  input  logic [COEF_W-1:0]        wr_data,
  input  logic [3:0]               rd_idx,
  output logic signed [COEF_W-1:0] rd_data
);

  // Entries at or above NUM_TAPS stay at zero and are never written.
  logic signed [COEF_W-1:0] h [MAX_TAPS];

  // Reset to the default taps, otherwise accept unlocked in-range writes.
  // NOTE: this is a tiny flop-based register file, so resetting it is cheap
  // and gives a known filter after reset; a real RAM would not be reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_TAPS; i++) begin
      if (!rst_n) begin
        h[i] <= (i < NUM_TAPS) ? COEF_W'(DEFAULT_COEF[i]) : '0;
      end else if (we && !lock && (int'(wr_idx) == i) && (i < NUM_TAPS)) begin
        h[i] <= wr_data;
      end
    end
  end

  assign rd_data = h[rd_idx];

endmodule

// File: rtl/fir_mac_param.sv
// Single-MAC memory-to-memory FIR engine. For each output sample it reads
// NUM_TAPS history samples from RAM port A (one per clock, 1-cycle read
// latency), accumulates sample*coefficient, scales the result and writes it
// through RAM port B.
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int NUM_TAPS  = 5,
  parameter int ADDR_W    = 10,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 8,
  parameter int SATURATE  = 1
) (
  input logic           clk,
  input logic           rst_n,
  fir_mac_param_if.slave bus
);

  localparam int         PROD_W = DATA_W + COEF_W;
  localparam logic [3:0] LAST_K = 4'(NUM_TAPS - 1);

  state_t                    state;
  state_t                    state_nx;
  logic [ADDR_W-1:0]         n;
  logic [ADDR_W-1:0]         in_base;
  logic [ADDR_W-1:0]         out_base;
  logic [ADDR_W-1:0]         count;
  logic [3:0]                k;
  logic [3:0]                tap_prev;
  logic                      valid_prev;
  logic                      done_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  sample;
  logic signed [DATA_W-1:0]  scaled;
  logic signed [COEF_W-1:0]  coef;
  logic signed [PROD_W-1:0]  prod;
  logic                      busy_i;
  logic                      rd_ok;
  logic                      last_sample;

  assign busy_i      = (state != ST_IDLE);
  // Taps reaching before the first sample are zero-padded: no read issued.
  assign rd_ok       = (state == ST_FETCH) && (n >= ADDR_W'(k));
  assign last_sample = (n == count - ADDR_W'(1));
  assign bus.busy    = busy_i;
  assign bus.done    = done_q;

  fir_coef_bank #(
    .COEF_W  (COEF_W),
    .NUM_TAPS(NUM_TAPS)
  ) u_coef (
    .clk    (clk),
    .rst_n  (rst_n),
    .lock   (busy_i),
    .we     (bus.coef_we),
    .wr_idx (bus.coef_idx),
    .wr_data(bus.coef_data),
    .rd_idx (tap_prev),
    .rd_data(coef)
  );

  // MAC term for the sample returned by last cycle's read, plus output scaling.
  always_comb begin
    sample  = $signed(bus.mem_data_out_a);
    prod    = PROD_W'(sample) * PROD_W'(coef);
    term    = valid_prev ? ACC_W'(prod) : '0;
    shifted = acc >>> OUT_SHIFT;
    if (SATURATE != 0) begin
      scaled = DATA_W'(sat_signed(64'(shifted), DATA_W));
    end else begin
      scaled = shifted[DATA_W-1:0];
    end
  end

  // State register.
  // NOTE: clocked state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and memory port drive.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx          = state;
    bus.mem_re_a      = 1'b0;
    bus.mem_addr_a    = '0;
    bus.mem_we_b      = 1'b0;
    bus.mem_addr_b    = '0;
    bus.mem_data_in_b = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = (bus.sample_count == '0) ? ST_IDLE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rd_ok) begin
          bus.mem_re_a   = 1'b1;
          bus.mem_addr_a = in_base + n - ADDR_W'(k);
        end
        if (k == LAST_K) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_we_b      = 1'b1;
        bus.mem_addr_b    = out_base + n;
        bus.mem_data_in_b = scaled;
        state_nx          = last_sample ? ST_IDLE : ST_FETCH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Run bookkeeping, tap pipeline and accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n          <= '0;
      k          <= '0;
      tap_prev   <= '0;
      valid_prev <= 1'b0;
      acc        <= '0;
      in_base    <= '0;
      out_base   <= '0;
      count      <= '0;
      done_q     <= 1'b0;
    end else begin
      valid_prev <= rd_ok;
      tap_prev   <= k;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            in_base  <= bus.input_addr;
            out_base <= bus.output_addr;
            count    <= bus.sample_count;
            n        <= '0;
            k        <= '0;
            done_q   <= (bus.sample_count == '0);
          end
        end
        ST_FETCH: begin
          acc <= (k == 4'd0) ? term : acc + term;
          k   <= (k == LAST_K) ? 4'd0 : k + 4'd1;
        end
        ST_DRAIN: begin
          acc <= acc + term;
        end
        ST_WRITE: begin
          k <= 4'd0;
          if (last_sample) begin
            done_q <= 1'b1;
          end else begin
            n <= n + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// Bench for fir_mac_param: three engines (OUT_SHIFT=8/SAT=1, OUT_SHIFT=0/SAT=1,
// OUT_SHIFT=0/SAT=0), each with its own sample RAM model. Directed runs push
// hand-computed writes into a per-engine queue; a per-engine monitor pops and
// compares on every mem_we_b.
module tb_fir_mac_param;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         sel = 0;
  logic       start_c = 1'b0;
  logic [9:0] in_c = '0;
  logic [9:0] out_c = '0;
  logic [9:0] cnt_c = '0;
  logic       coef_we_c = 1'b0;
  logic [3:0] cidx_c = '0;
  logic [7:0] cdata_c = '0;
  logic       pre_we = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] we_v;
  logic [2:0] re_v;
  int         wr_v [3];

  exp_t       exp_q [3][$];
  logic [7:0] exp_vals [$];
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  int         t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int OS  = (g == 0) ? 8 : 0;
    localparam int SAT = (g == 2) ? 0 : 1;

    fir_mac_param_if #(.DATA_W(8), .COEF_W(8), .ADDR_W(10)) bus ();

    fir_mac_param #(
      .DATA_W(8), .COEF_W(8), .NUM_TAPS(5), .ADDR_W(10), .ACC_W(20),
      .OUT_SHIFT(OS), .SATURATE(SAT)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
    );

    logic [7:0] mem [1024];
    int         wr_cnt = 0;

    assign bus.start        = start_c && (sel == g);
    assign bus.input_addr   = in_c;
    assign bus.output_addr  = out_c;
    assign bus.sample_count = cnt_c;
    assign bus.coef_we      = coef_we_c && (sel == g);
    assign bus.coef_idx     = cidx_c;
    assign bus.coef_data    = cdata_c;
    assign busy_v[g]        = bus.busy;
    assign done_v[g]        = bus.done;
    assign we_v[g]          = bus.mem_we_b;
    assign re_v[g]          = bus.mem_re_a;
    assign wr_v[g]          = wr_cnt;

    // Dual-port RAM model with 1-cycle read latency and a preload port.
    always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_data_in_b;
      if (bus.mem_re_a) bus.mem_data_out_a <= mem[bus.mem_addr_a];
    end

    // Scoreboard monitor: every write must match the oldest expected entry.
    always @(negedge clk) begin
      if (bus.mem_we_b) begin
        exp_t e;
        wr_cnt++;
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d_unexpected_write addr=%0d data=%0d", g,
                   bus.mem_addr_b, bus.mem_data_in_b);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("u%0d_wr_addr", g), 32'(bus.mem_addr_b), 32'(e.addr));
          check($sformatf("u%0d_wr_data@%0d", g, e.addr), 32'(bus.mem_data_in_b), 32'(e.data));
        end
      end
    end
  end

  task automatic push_seq(input int g, input int base);
    exp_t e;
    foreach (exp_vals[i]) begin
      e.addr = 10'(base + i);
      e.data = exp_vals[i];
      exp_q[g].push_back(e);
    end
  endtask

  task automatic preload(input int addr, input logic [7:0] data);
    pre_we = 1'b1;
    pre_addr = 10'(addr);
    pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic start_run(input int g, input int in_a, input int out_a, input int cnt);
    sel = g;
    in_c = 10'(in_a);
    out_c = 10'(out_a);
    cnt_c = 10'(cnt);
    start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_c = 1'b0;
    t0 = cycle;
  endtask

  task automatic wait_done(input int g, input int exp_lat);
    int lat;
    lat = cycle - t0 + 1;
    while (!done_v[g] && lat < 600) begin
      @(negedge clk);
      lat = cycle - t0 + 1;
    end
    check($sformatf("u%0d_done_latency", g), 32'(lat), 32'(exp_lat));
  endtask

  task automatic load_coef(input int idx, input logic [7:0] val);
    coef_we_c = 1'b1;
    cidx_c = 4'(idx);
    cdata_c = val;
    @(negedge clk);
    coef_we_c = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w0;
    int lim;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("u%0d_rst_busy", g), 32'(busy_v[g]), 0);
      check($sformatf("u%0d_rst_done", g), 32'(done_v[g]), 0);
      check($sformatf("u%0d_rst_we", g), 32'(we_v[g]), 0);
      check($sformatf("u%0d_rst_re", g), 32'(re_v[g]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) preload(i, 8'd100);
    preload(1022, 8'd100);
    preload(1023, 8'd100);
    for (int i = 0; i < 6; i++) preload(16 + i, (i == 0) ? 8'd10 : 8'd0);
    for (int i = 0; i < 5; i++) preload(32 + i, 8'h9C);
    for (int i = 0; i < 6; i++) preload(48 + i, 8'(i));

    // Engine 0: zero-length run, then default filter on constant 100.
    w0 = wr_v[0];
    start_run(0, 0, 500, 0);
    wait_done(0, 1);
    repeat (10) @(negedge clk);
    check("u0_count0_no_write", 32'(wr_v[0] - w0), 0);

    exp_vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
    push_seq(0, 100);
    start_run(0, 0, 100, 8);
    check("u0_busy_first_fetch", 32'(busy_v[0]), 1);
    check("u0_done_cleared", 32'(done_v[0]), 0);
    @(negedge clk);
    in_c = 10'd16;
    out_c = 10'd300;
    cnt_c = 10'd2;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    wait_done(0, 57);

    // Input window wrapping past address 1023.
    exp_vals = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    push_seq(0, 200);
    start_run(0, 1022, 200, 5);
    wait_done(0, 36);

    // Engine 1: unscaled, saturating.
    exp_vals = '{8'd10, 8'd20, 8'd30, 8'd20, 8'd10, 8'd0};
    push_seq(1, 120);
    start_run(1, 16, 120, 6);
    wait_done(1, 43);

    exp_vals = '{8'h64, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    push_seq(1, 130);
    start_run(1, 0, 130, 5);
    wait_done(1, 36);

    exp_vals = '{8'h9C, 8'h80, 8'h80, 8'h80, 8'h80};
    push_seq(1, 140);
    start_run(1, 32, 140, 5);
    wait_done(1, 36);

    // Differentiator taps; a write attempted mid-run must be ignored.
    sel = 1;
    load_coef(0, 8'd1);
    load_coef(1, 8'hFF);
    load_coef(2, 8'd0);
    load_coef(3, 8'd0);
    load_coef(4, 8'd0);
    exp_vals = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    push_seq(1, 150);
    start_run(1, 48, 150, 6);
    @(negedge clk);
    load_coef(1, 8'd7);
    wait_done(1, 43);

    // Reset during the FETCH phase of sample 2.
    exp_vals = '{8'd0, 8'd1};
    push_seq(1, 160);
    w0 = wr_v[1];
    start_run(1, 48, 160, 6);
    lim = 0;
    while (wr_v[1] < w0 + 2 && lim < 300) begin
      @(posedge clk);
      lim++;
    end
    check("u1_writes_before_rst", 32'(wr_v[1] - w0), 2);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("u1_midrst_busy", 32'(busy_v[1]), 0);
    check("u1_midrst_done", 32'(done_v[1]), 0);
    check("u1_midrst_we", 32'(we_v[1]), 0);
    check("u1_midrst_re", 32'(re_v[1]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("u1_midrst_queue", 32'(exp_q[1].size()), 0);

    // Default taps restored; output window wraps past address 1023.
    exp_vals = '{8'd10, 8'd20, 8'd30, 8'd20, 8'd10, 8'd0};
    push_seq(1, 1022);
    start_run(1, 16, 1022, 6);
    wait_done(1, 43);

    // Engine 2: unscaled, truncating.
    exp_vals = '{8'h64, 8'h2C, 8'h58, 8'h20, 8'h84};
    push_seq(2, 130);
    start_run(2, 0, 130, 5);
    wait_done(2, 36);

    exp_vals = '{8'h9C, 8'hD4, 8'hA8, 8'hE0, 8'h7C};
    push_seq(2, 140);
    start_run(2, 32, 140, 5);
    wait_done(2, 36);

    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("u%0d_pending_writes", g), 32'(exp_q[g].size()), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
